hazard_tracker: RTL and testbench
=================================

HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 SHALL have ports `clk` (in, 1; single clock, all state updates on rising edge) and `reset` (in, 1; asynchronous, active-low).
REQ-002 SHALL have input `stall` (1): the stall request for the current cycle, driven by the pipeline stall unit.
REQ-003 SHALL have inputs `D_A3` (5), `D_rs` (5), `D_rt` (5): the D-stage instruction's destination, source-1 and source-2 register indices.
REQ-004 SHALL have input `D_T_new` (2): the D-stage instruction's result latency, counted from entry into E.
REQ-005 SHALL have outputs `E_A3`, `M_A3`, `W_A3` (5 each): the in-flight destination register per stage.
REQ-006 SHALL have outputs `E_T_new`, `M_T_new`, `W_T_new` (2 each): the remaining result latency per stage, consumed by the stall unit.
REQ-007 SHALL have outputs `E_fwd_rs`, `E_fwd_rt` (2 each): the E-stage operand forwarding select (0 = register file, 1 = M, 2 = W; 3 unused).
REQ-008 SHALL have output `stall_cnt` (32): the count of stalled cycles (see Configuration).

Function
REQ-009 E, M and W SHALL each be a registered stage holding {A3, T_new}; E SHALL additionally hold {rs, rt}.
REQ-010 When `stall`=0, each rising edge SHALL load E with {D_A3, D_T_new, D_rs, D_rt}.
REQ-011 When `stall`=1, each rising edge SHALL load E with a bubble: A3=0, T_new=0, rs=0, rt=0. D-stage inputs are held externally.
REQ-012 M and W SHALL advance every cycle regardless of `stall`: M <= E, W <= M.
REQ-013 T_new SHALL decrement by 1 per stage advance, saturating at 0: M_T_new <= sat(E_T_new-1), W_T_new <= sat(M_T_new-1).
REQ-014 Write clamp: D_T_new=3 SHALL be clamped to 2 on load into E.
REQ-015 Write clamp: if D_A3=0, E_T_new SHALL be loaded as 0, since register 0 is never a hazard source.
REQ-016 The A3 and T_new outputs SHALL be driven directly from the stage registers (zero combinational latency).
REQ-017 E_fwd_rs SHALL be 1 if E_rs!=0, M_A3==E_rs and M_T_new==0.
REQ-018 Otherwise E_fwd_rs SHALL be 2 if E_rs!=0 and W_A3==E_rs.
REQ-019 Otherwise E_fwd_rs SHALL be 0.
REQ-020 E_fwd_rt SHALL follow REQ-017..019 with rt in place of rs.
REQ-021 Forwarding selects SHALL be combinational from the stage registers.
REQ-022 M priority: when M and W both match, M SHALL be selected, as it holds the younger producer.
REQ-023 If M matches with M_T_new>0 (result not ready), the select SHALL fall through to W or 0; stall correctness is the stall unit's responsibility.
REQ-024 Back-to-back stalls SHALL insert one bubble per stalled cycle, with no limit.

Reset
REQ-025 Assertion of `reset` (low) SHALL immediately clear all stage registers to 0, giving all outputs 0, independent of `clk`.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight state.
REQ-027 The first rising edge after deassertion SHALL behave per REQ-010/011.

Configuration
REQ-028 Feature macro `HAZARD_TRACKER_STALL_CNT_EN` SHALL control the stall counter.
REQ-029 With the macro defined, `stall_cnt` SHALL increment by 1 on each rising edge with `stall`=1, wrap from 0xFFFFFFFF to 0, and reset to 0.
REQ-030 With the macro undefined, `stall_cnt` SHALL be tied to constant 0 and no counter logic SHALL be synthesised; the port list is unchanged.

Verification
REQ-031 Load tracking: D={A3=8, T_new=2, rs=0, rt=0}, stall=0, 3 edges -> E_T_new=2, then M_T_new=1, then W_T_new=0; A3=8 in each stage in turn.
REQ-032 Stall bubble: E holds {A3=5, T_new=1}, stall=1 for 2 edges -> E={0,0} after each; M={5,0} after edge 1, then W={5,0}; stall_cnt=2 (macro on) or 0 (macro off).
REQ-033 Forward priority: M_A3=W_A3=9, M_T_new=0, E_rs=9, E_rt=9 -> E_fwd_rs=1, E_fwd_rt=1; then M_A3=3 -> both select 2.
REQ-034 Zero register: D={A3=0, T_new=2, rs=0} -> E_T_new=0; with E_rs=0 and W_A3=0 -> E_fwd_rs=0.
REQ-035 Clamp and not-ready: D_T_new=3 -> E_T_new=2; M_A3=E_rt=7 with M_T_new=1 and W_A3!=7 -> E_fwd_rt=0.
REQ-036 Async reset: reset low between edges with all stages loaded -> all outputs 0 before the next edge; stall_cnt counts again from 0 after release.

Source files
------------

// File: rtl/hazard_tracker.sv
// ---------------------------------------------------------------------------
// hazard_tracker
//
// Tracks the destination register and remaining result latency (T_new) of
// the instructions in flight in the E, M and W pipeline stages, and computes
// the E-stage operand forwarding selects from that state.
//
// Optional feature macro: HAZARD_TRACKER_STALL_CNT_EN
//   defined   -> stall_cnt counts rising edges with stall=1 (wraps at 2^32)
//   undefined -> stall_cnt is tied to 0 and no counter is built
//
// Ports:
//   clk                 in   rising-edge clock
//   reset               in   asynchronous, active-low reset
//   stall               in   stall request: load a bubble into E this edge
//   D_A3, D_rs, D_rt    in   D-stage destination / source register indices
//   D_T_new             in   D-stage result latency, counted from entry to E
//   E_A3, M_A3, W_A3    out  destination register per stage
//   E_T_new .. W_T_new  out  remaining result latency per stage
//   E_fwd_rs, E_fwd_rt  out  forwarding select (0 = regfile, 1 = M, 2 = W)
//   stall_cnt           out  number of stalled cycles
// ---------------------------------------------------------------------------
module hazard_tracker (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [4:0]  D_A3,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_T_new,
  output logic [4:0]  E_A3,
  output logic [4:0]  M_A3,
  output logic [4:0]  W_A3,
  output logic [1:0]  E_T_new,
  output logic [1:0]  M_T_new,
  output logic [1:0]  W_T_new,
  output logic [1:0]  E_fwd_rs,
  output logic [1:0]  E_fwd_rt,
  output logic [31:0] stall_cnt
);

  logic [4:0] r_e_a3, r_e_rs, r_e_rt, r_m_a3, r_w_a3;
  logic [1:0] r_e_tnew, r_m_tnew, r_w_tnew;

  logic [1:0] w_d_tnew;
  logic [1:0] w_m_tnew_next;
  logic [1:0] w_w_tnew_next;

  // Latency entering E: a write to register 0 never creates a hazard, and
  // a latency of 3 cannot occur in this pipeline so it is clamped to 2.
  always_comb begin
    w_d_tnew = D_T_new;
    if (D_A3 == 5'd0) begin
      w_d_tnew = 2'd0;
    end else if (D_T_new == 2'd3) begin
      w_d_tnew = 2'd2;
    end
  end

  // One stage of progress consumes one cycle of latency, never below 0.
  assign w_m_tnew_next = (r_e_tnew == 2'd0) ? 2'd0 : r_e_tnew - 2'd1;
  assign w_w_tnew_next = (r_m_tnew == 2'd0) ? 2'd0 : r_m_tnew - 2'd1;

  // E takes the D-stage instruction or a bubble; M and W always advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_e_a3   <= 5'd0;
      r_e_rs   <= 5'd0;
      r_e_rt   <= 5'd0;
      r_e_tnew <= 2'd0;
      r_m_a3   <= 5'd0;
      r_m_tnew <= 2'd0;
      r_w_a3   <= 5'd0;
      r_w_tnew <= 2'd0;
    end else begin
      if (stall) begin
        r_e_a3   <= 5'd0;
        r_e_rs   <= 5'd0;
        r_e_rt   <= 5'd0;
        r_e_tnew <= 2'd0;
      end else begin
        r_e_a3   <= D_A3;
        r_e_rs   <= D_rs;
        r_e_rt   <= D_rt;
        r_e_tnew <= w_d_tnew;
      end
      r_m_a3   <= r_e_a3;
      r_m_tnew <= w_m_tnew_next;
      r_w_a3   <= r_m_a3;
      r_w_tnew <= w_w_tnew_next;
    end
  end

  // M holds the younger producer, so it wins over W. A matching M whose
  // result is not yet ready falls through; the stall unit covers that case.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] m_a3,
                                         input logic [1:0] m_tnew,
                                         input logic [4:0] w_a3);
    logic [1:0] sel;
    sel = 2'd0;
    if (src != 5'd0) begin
      if ((m_a3 == src) && (m_tnew == 2'd0)) begin
        sel = 2'd1;
      end else if (w_a3 == src) begin
        sel = 2'd2;
      end
    end
    return sel;
  endfunction

  assign E_fwd_rs = fwd_sel(r_e_rs, r_m_a3, r_m_tnew, r_w_a3);
  assign E_fwd_rt = fwd_sel(r_e_rt, r_m_a3, r_m_tnew, r_w_a3);

  assign E_A3    = r_e_a3;
  assign M_A3    = r_m_a3;
  assign W_A3    = r_w_a3;
  assign E_T_new = r_e_tnew;
  assign M_T_new = r_m_tnew;
  assign W_T_new = r_w_tnew;

`ifdef HAZARD_TRACKER_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Free-running count of bubbles inserted; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= 32'd0;
    end else if (stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// ---------------------------------------------------------------------------
// tb_hazard_tracker
//
// Directed test of hazard_tracker: a linear sequence of stimulus steps with
// hand-computed expected values, each compared by an immediate assertion.
// Works with or without HAZARD_TRACKER_STALL_CNT_EN defined.
// ---------------------------------------------------------------------------
module tb_hazard_tracker;

`ifdef HAZARD_TRACKER_STALL_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic        clk;
  logic        reset;
  logic        stall;
  logic [4:0]  D_A3, D_rs, D_rt;
  logic [1:0]  D_T_new;
  logic [4:0]  E_A3, M_A3, W_A3;
  logic [1:0]  E_T_new, M_T_new, W_T_new;
  logic [1:0]  E_fwd_rs, E_fwd_rt;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_tracker dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .D_A3      (D_A3),
    .D_rs      (D_rs),
    .D_rt      (D_rt),
    .D_T_new   (D_T_new),
    .E_A3      (E_A3),
    .M_A3      (M_A3),
    .W_A3      (W_A3),
    .E_T_new   (E_T_new),
    .M_T_new   (M_T_new),
    .W_T_new   (W_T_new),
    .E_fwd_rs  (E_fwd_rs),
    .E_fwd_rt  (E_fwd_rt),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [4:0] a3, input logic [1:0] tn,
                       input logic [4:0] rs, input logic [4:0] rt);
    stall   = s;
    D_A3    = a3;
    D_T_new = tn;
    D_rs    = rs;
    D_rt    = rt;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 5'd0, 2'd0, 5'd0, 5'd0);

    // Reset state
    #2;
    chk("rst_E_A3",      32'(E_A3), 0);
    chk("rst_W_T_new",   32'(W_T_new), 0);
    chk("rst_fwd_rs",    32'(E_fwd_rs), 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    drive(1'b1, 5'd8, 2'd2, 5'd8, 5'd8);
    tick();
    chk("rst_held_E_A3", 32'(E_A3), 0);
    reset = 1'b1;
    drive(1'b0, 5'd0, 2'd0, 5'd0, 5'd0);

    // Load tracking: A3=8, T_new=2 moving through E, M, W
    drive(1'b0, 5'd8, 2'd2, 5'd0, 5'd0);
    tick();
    chk("load_E_A3",    32'(E_A3), 8);
    chk("load_E_T_new", 32'(E_T_new), 2);
    drive(1'b0, 5'd0, 2'd0, 5'd0, 5'd0);
    tick();
    chk("load_M_A3",    32'(M_A3), 8);
    chk("load_M_T_new", 32'(M_T_new), 1);
    tick();
    chk("load_W_A3",    32'(W_A3), 8);
    chk("load_W_T_new", 32'(W_T_new), 0);

    // Stall bubbles: E={5,1}, then two stalled edges
    drive(1'b0, 5'd5, 2'd1, 5'd0, 5'd0);
    tick();
    chk("stl_pre_E_A3", 32'(E_A3), 5);
    stall = 1'b1;
    tick();
    chk("stl1_E_A3",    32'(E_A3), 0);
    chk("stl1_E_T_new", 32'(E_T_new), 0);
    chk("stl1_M_A3",    32'(M_A3), 5);
    chk("stl1_M_T_new", 32'(M_T_new), 0);
    tick();
    chk("stl2_E_A3",    32'(E_A3), 0);
    chk("stl2_M_A3",    32'(M_A3), 0);
    chk("stl2_W_A3",    32'(W_A3), 5);
    chk("stl2_W_T_new", 32'(W_T_new), 0);
    chk("stl2_cnt",     stall_cnt, 32'(2 * CNT_ON));

    // Forward priority: M and W both hold 9, then M moves to 3
    drive(1'b0, 5'd9, 2'd1, 5'd0, 5'd0);
    tick();
    tick();
    drive(1'b0, 5'd3, 2'd1, 5'd9, 5'd9);
    tick();
    chk("fp_M_T_new", 32'(M_T_new), 0);
    chk("fp_fwd_rs_M", 32'(E_fwd_rs), 1);
    chk("fp_fwd_rt_M", 32'(E_fwd_rt), 1);
    drive(1'b0, 5'd0, 2'd0, 5'd9, 5'd9);
    tick();
    chk("fp_M_A3",     32'(M_A3), 3);
    chk("fp_fwd_rs_W", 32'(E_fwd_rs), 2);
    chk("fp_fwd_rt_W", 32'(E_fwd_rt), 2);

    // Zero register: write to r0 carries no latency, rs=0 never forwards
    drive(1'b0, 5'd0, 2'd2, 5'd0, 5'd0);
    tick();
    chk("z0_E_T_new", 32'(E_T_new), 0);
    tick();
    chk("z0_W_A3",    32'(W_A3), 0);
    chk("z0_fwd_rs",  32'(E_fwd_rs), 0);

    // Clamp and not-ready producer in M
    drive(1'b0, 5'd7, 2'd3, 5'd0, 5'd0);
    tick();
    chk("clmp_E_T_new", 32'(E_T_new), 2);
    drive(1'b0, 5'd0, 2'd0, 5'd0, 5'd7);
    tick();
    chk("nr_M_T_new", 32'(M_T_new), 1);
    chk("nr_fwd_rt",  32'(E_fwd_rt), 0);
    tick();
    chk("nr_W_fwd_rt", 32'(E_fwd_rt), 2);
    chk("nr_W_fwd_rs", 32'(E_fwd_rs), 0);

    // Async reset mid-operation
    drive(1'b0, 5'd4, 2'd2, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd6, 2'd2, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd10, 2'd1, 5'd4, 5'd6);
    tick();
    chk("ar_pre_E_A3",   32'(E_A3), 10);
    chk("ar_pre_M_T_new", 32'(M_T_new), 1);
    chk("ar_pre_fwd_rs", 32'(E_fwd_rs), 2);
    chk("ar_pre_fwd_rt", 32'(E_fwd_rt), 0);
    chk("ar_pre_cnt",    stall_cnt, 32'(2 * CNT_ON));
    reset = 1'b0;
    #2;
    chk("ar_E_A3",    32'(E_A3), 0);
    chk("ar_E_T_new", 32'(E_T_new), 0);
    chk("ar_M_A3",    32'(M_A3), 0);
    chk("ar_W_A3",    32'(W_A3), 0);
    chk("ar_fwd_rs",  32'(E_fwd_rs), 0);
    chk("ar_cnt",     stall_cnt, 0);
    #2;
    reset = 1'b1;
    stall = 1'b1;
    tick();
    chk("ar_post_E_A3", 32'(E_A3), 0);
    chk("ar_post_cnt",  stall_cnt, 32'(CNT_ON));
    stall = 1'b0;
    tick();
    chk("ar_post_E_A3_load", 32'(E_A3), 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
